// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths and FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned AddrWDefault    = 8;
  localparam int unsigned InstrWDefault   = 16;
  localparam int unsigned RasDepthDefault = 4;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module fetch_unit_return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  top_q, top_next, top_prev;
  logic [CntW-1:0]  count_q;

  // top_q is the next free slot; the most recent entry sits just below it.
  always_comb begin
    top_next = (top_q == PtrW'(DEPTH - 1)) ? '0 : top_q + PtrW'(1);
    top_prev = (top_q == '0) ? PtrW'(DEPTH - 1) : top_q - PtrW'(1);
  end

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign popData = mem_q[top_prev];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      top_q <= top_next;
      if (!full) count_q <= count_q + CntW'(1);
    end else if (pop && !empty) begin
      top_q   <= top_prev;
      count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[top_q] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and registers the fetched word.
// Define FETCH_RAS_EN to add a return-address stack for call/return redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W       = AddrWDefault,
  parameter int unsigned        INSTR_W      = InstrWDefault,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        RAS_DEPTH    = RasDepthDefault
) (
  input  logic               clk,
  input  logic               resetN,
  output logic [ADDR_W-1:0]  instructionAddress,
  input  logic [INSTR_W-1:0] instructionInput,
  input  logic               stall,
  input  logic               halt,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  input  logic               callTaken,
  input  logic               retTaken,
  output logic [INSTR_W-1:0] instructionReg,
  output logic [ADDR_W-1:0]  irAddress,
  output logic               irValid,
  output logic               rasError
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, ir_addr_q, target;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q, redirect;

`ifdef FETCH_RAS_EN
  logic              push, pop, ras_full, ras_empty, ras_err_q;
  logic [ADDR_W-1:0] pop_data, push_data;

  // Call beats return beats branch; calls and branches share branchTarget.
  always_comb begin
    redirect  = (state_q != StBoot) && (callTaken || retTaken || branchTaken);
    push      = redirect && callTaken;
    pop       = redirect && !callTaken && retTaken;
    push_data = ir_addr_q + ADDR_W'(1);
    target    = branchTarget;
    if (pop) target = ras_empty ? RESET_VECTOR : pop_data;
  end

  fetch_unit_return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .resetN   (resetN),
    .push     (push),
    .pop      (pop),
    .pushData (push_data),
    .popData  (pop_data),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ras_err_q <= 1'b0;
    end else if ((push && ras_full) || (pop && ras_empty)) begin
      ras_err_q <= 1'b1;
    end
  end

  assign rasError = ras_err_q;
`else
  logic unused_cfg;

  always_comb begin
    redirect = (state_q != StBoot) && (callTaken || branchTaken);
    target   = branchTarget;
  end

  assign unused_cfg = retTaken ^ (RAS_DEPTH != 0);
  assign rasError   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      ir_q       <= '0;
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (redirect) begin
            pc_q       <= target;
            ir_valid_q <= 1'b0;
          end else if (halt) begin
            state_q    <= StHalted;
            ir_valid_q <= 1'b0;
          end else if (!stall) begin
            ir_q       <= instructionInput;
            ir_addr_q  <= pc_q;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + ADDR_W'(1);
          end
        end
        StHalted: begin
          // Leaving halt spends one edge re-entering RUN before the next capture.
          if (redirect) pc_q <= target;
          if (!halt) state_q <= StRun;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign instructionAddress = pc_q;
  assign instructionReg     = ir_q;
  assign irAddress          = ir_addr_q;
  assign irValid            = ir_valid_q;

endmodule
